// File: rtl/univ_reg_n.sv
// univ_reg_n: parametrised N-bit universal register.
//
// Synchronous clear and preset, parallel load, shift, rotate and
// increment/decrement. Qb and ZERO are decoded combinationally from Q.
//
// Optional feature macro: UREG_CARRY_EN
//   defined   - CO port and its register exist.
//   undefined - CO is removed; shifted-out bits are dropped, INC/DEC wrap silently.
//
// Parameters:
//   WIDTH      register width, 2..64
//   PRESET_VAL value loaded while PRE_b is low
// Ports:
//   CLK    rising-edge clock
//   CLR_b  synchronous active-low clear (highest priority)
//   PRE_b  synchronous active-low preset
//   EN     operation enable; hold when low
//   MODE   operation select (HOLD/LOAD/SHL/SHR/ROL/ROR/INC/DEC)
//   D      parallel load data
//   SIN    serial input for shifts
//   Q      register value
//   Qb     bitwise complement of Q
//   ZERO   high when Q == 0
//   CO     carry/borrow/shift-out flag (UREG_CARRY_EN only)
module univ_reg_n #(
  parameter int unsigned          WIDTH      = 8,
  parameter logic [WIDTH-1:0]     PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             CLR_b,
  input  logic             PRE_b,
  input  logic             EN,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] D,
  input  logic             SIN,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             ZERO
`ifdef UREG_CARRY_EN
  ,
  output logic             CO
`endif
);

  typedef enum logic [2:0] {
    ModeHold = 3'b000,
    ModeLoad = 3'b001,
    ModeShl  = 3'b010,
    ModeShr  = 3'b011,
    ModeRol  = 3'b100,
    ModeRor  = 3'b101,
    ModeInc  = 3'b110,
    ModeDec  = 3'b111
  } mode_e;

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;
  mode_e            w_mode;

  assign w_mode = mode_e'(MODE);

`ifdef UREG_CARRY_EN
  logic r_co;
  logic w_co_next;
`endif

  // Next-state for EN high; clear/preset/enable priority is applied in the register.
  always_comb begin
    w_q_next  = r_q;
`ifdef UREG_CARRY_EN
    w_co_next = r_co;
`endif
    unique case (w_mode)
      ModeHold: begin
        w_q_next = r_q;
      end
      ModeLoad: begin
        w_q_next  = D;
`ifdef UREG_CARRY_EN
        w_co_next = 1'b0;
`endif
      end
      ModeShl: begin
        w_q_next  = {r_q[WIDTH-2:0], SIN};
`ifdef UREG_CARRY_EN
        w_co_next = r_q[WIDTH-1];
`endif
      end
      ModeShr: begin
        w_q_next  = {SIN, r_q[WIDTH-1:1]};
`ifdef UREG_CARRY_EN
        w_co_next = r_q[0];
`endif
      end
      ModeRol: begin
        w_q_next  = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
`ifdef UREG_CARRY_EN
        w_co_next = r_q[WIDTH-1];
`endif
      end
      ModeRor: begin
        w_q_next  = {r_q[0], r_q[WIDTH-1:1]};
`ifdef UREG_CARRY_EN
        w_co_next = r_q[0];
`endif
      end
      ModeInc: begin
        w_q_next  = r_q + One;
`ifdef UREG_CARRY_EN
        w_co_next = &r_q;  // wrap from all ones
`endif
      end
      ModeDec: begin
        w_q_next  = r_q - One;
`ifdef UREG_CARRY_EN
        w_co_next = ~|r_q;  // borrow from zero
`endif
      end
      default: begin
        w_q_next = r_q;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!CLR_b) begin
      r_q  <= '0;
`ifdef UREG_CARRY_EN
      r_co <= 1'b0;
`endif
    end else if (!PRE_b) begin
      r_q  <= PRESET_VAL;
`ifdef UREG_CARRY_EN
      r_co <= 1'b0;
`endif
    end else if (EN) begin
      r_q  <= w_q_next;
`ifdef UREG_CARRY_EN
      r_co <= w_co_next;
`endif
    end
  end

  assign Q    = r_q;
  assign Qb   = ~r_q;
  assign ZERO = (r_q == '0);
`ifdef UREG_CARRY_EN
  assign CO   = r_co;
`endif

endmodule

// File: tb/tb_univ_reg_n.sv
// Directed bench for univ_reg_n: an 8-bit instance with default preset and a
// 2-bit instance with preset 2'b10 share all control inputs.
module tb_univ_reg_n;

  logic       CLK;
  logic       CLR_b;
  logic       PRE_b;
  logic       EN;
  logic [2:0] MODE;
  logic [7:0] D;
  logic       SIN;
  logic [7:0] Q;
  logic [7:0] Qb;
  logic       ZERO;
  logic [1:0] Q2;
  logic [1:0] Qb2;
  logic       ZERO2;
`ifdef UREG_CARRY_EN
  logic       CO;
  logic       CO2;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [2:0] MHold = 3'b000, MLoad = 3'b001, MShl = 3'b010, MShr = 3'b011;
  localparam logic [2:0] MRol  = 3'b100, MRor  = 3'b101, MInc = 3'b110, MDec = 3'b111;

  univ_reg_n #(
    .WIDTH(8)
  ) u_dut (
    .CLK  (CLK),
    .CLR_b(CLR_b),
    .PRE_b(PRE_b),
    .EN   (EN),
    .MODE (MODE),
    .D    (D),
    .SIN  (SIN),
    .Q    (Q),
    .Qb   (Qb),
    .ZERO (ZERO)
`ifdef UREG_CARRY_EN
    ,
    .CO   (CO)
`endif
  );

  univ_reg_n #(
    .WIDTH     (2),
    .PRESET_VAL(2'b10)
  ) u_dut2 (
    .CLK  (CLK),
    .CLR_b(CLR_b),
    .PRE_b(PRE_b),
    .EN   (EN),
    .MODE (MODE),
    .D    (D[1:0]),
    .SIN  (SIN),
    .Q    (Q2),
    .Qb   (Qb2),
    .ZERO (ZERO2)
`ifdef UREG_CARRY_EN
    ,
    .CO   (CO2)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Apply one set of inputs across a rising edge, then settle before sampling.
  task automatic step(input logic clr, input logic pre, input logic en, input logic [2:0] mode,
                      input logic [7:0] d, input logic sin);
    CLR_b = clr;
    PRE_b = pre;
    EN    = en;
    MODE  = mode;
    D     = d;
    SIN   = sin;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b1, MHold, 8'h00, 1'b0);
    n_checks++; if (Q !== 8'h00) begin n_fail++; $display("FAIL clr_q: got %h want 00", Q); end
    n_checks++; if (Qb !== 8'hFF) begin n_fail++; $display("FAIL clr_qb: got %h want FF", Qb); end
    n_checks++; if (ZERO !== 1'b1) begin n_fail++; $display("FAIL clr_zero: got %b want 1", ZERO); end
`ifdef UREG_CARRY_EN
    n_checks++; if (CO !== 1'b0) begin n_fail++; $display("FAIL clr_co: got %b want 0", CO); end
`endif
    step(1'b1, 1'b0, 1'b1, MHold, 8'h00, 1'b0);
    n_checks++; if (Q !== 8'hFF) begin n_fail++; $display("FAIL pre_q: got %h want FF", Q); end
    n_checks++; if (Qb !== 8'h00) begin n_fail++; $display("FAIL pre_qb: got %h want 00", Qb); end
    n_checks++; if (ZERO !== 1'b0) begin n_fail++; $display("FAIL pre_zero: got %b want 0", ZERO); end
`ifdef UREG_CARRY_EN
    n_checks++; if (CO !== 1'b0) begin n_fail++; $display("FAIL pre_co: got %b want 0", CO); end
`endif
  endtask

  task automatic test_shift();
    step(1'b1, 1'b1, 1'b1, MLoad, 8'h96, 1'b0);
    n_checks++; if (Q !== 8'h96) begin n_fail++; $display("FAIL load_q: got %h want 96", Q); end
    step(1'b1, 1'b1, 1'b1, MShl, 8'h00, 1'b1);
    n_checks++; if (Q !== 8'h2D) begin n_fail++; $display("FAIL shl_q: got %h want 2D", Q); end
`ifdef UREG_CARRY_EN
    n_checks++; if (CO !== 1'b1) begin n_fail++; $display("FAIL shl_co: got %b want 1", CO); end
`endif
    step(1'b1, 1'b1, 1'b1, MShr, 8'h00, 1'b0);
    n_checks++; if (Q !== 8'h16) begin n_fail++; $display("FAIL shr_q: got %h want 16", Q); end
`ifdef UREG_CARRY_EN
    n_checks++; if (CO !== 1'b1) begin n_fail++; $display("FAIL shr_co: got %b want 1", CO); end
`endif
    step(1'b1, 1'b1, 1'b1, MShr, 8'h00, 1'b1);
    n_checks++; if (Q !== 8'h8B) begin n_fail++; $display("FAIL shr_sin_q: got %h want 8B", Q); end
`ifdef UREG_CARRY_EN
    n_checks++; if (CO !== 1'b0) begin n_fail++; $display("FAIL shr_sin_co: got %b want 0", CO); end
`endif
  endtask

  task automatic test_rotate();
    step(1'b1, 1'b1, 1'b1, MLoad, 8'h81, 1'b0);
    step(1'b1, 1'b1, 1'b1, MRol, 8'h00, 1'b0);
    n_checks++; if (Q !== 8'h03) begin n_fail++; $display("FAIL rol_q: got %h want 03", Q); end
`ifdef UREG_CARRY_EN
    n_checks++; if (CO !== 1'b1) begin n_fail++; $display("FAIL rol_co: got %b want 1", CO); end
`endif
    step(1'b1, 1'b1, 1'b1, MRor, 8'h00, 1'b0);
    n_checks++; if (Q !== 8'h81) begin n_fail++; $display("FAIL ror1_q: got %h want 81", Q); end
`ifdef UREG_CARRY_EN
    n_checks++; if (CO !== 1'b1) begin n_fail++; $display("FAIL ror1_co: got %b want 1", CO); end
`endif
    step(1'b1, 1'b1, 1'b1, MRor, 8'h00, 1'b0);
    n_checks++; if (Q !== 8'hC0) begin n_fail++; $display("FAIL ror2_q: got %h want C0", Q); end
`ifdef UREG_CARRY_EN
    n_checks++; if (CO !== 1'b1) begin n_fail++; $display("FAIL ror2_co: got %b want 1", CO); end
`endif
  endtask

  task automatic test_incdec();
    step(1'b1, 1'b1, 1'b1, MLoad, 8'hFE, 1'b0);
    step(1'b1, 1'b1, 1'b1, MInc, 8'h00, 1'b0);
    n_checks++; if (Q !== 8'hFF) begin n_fail++; $display("FAIL inc1_q: got %h want FF", Q); end
`ifdef UREG_CARRY_EN
    n_checks++; if (CO !== 1'b0) begin n_fail++; $display("FAIL inc1_co: got %b want 0", CO); end
`endif
    step(1'b1, 1'b1, 1'b1, MInc, 8'h00, 1'b0);
    n_checks++; if (Q !== 8'h00) begin n_fail++; $display("FAIL inc_wrap_q: got %h want 00", Q); end
    n_checks++; if (ZERO !== 1'b1) begin n_fail++; $display("FAIL inc_wrap_zero: got %b want 1", ZERO); end
`ifdef UREG_CARRY_EN
    n_checks++; if (CO !== 1'b1) begin n_fail++; $display("FAIL inc_wrap_co: got %b want 1", CO); end
`endif
    step(1'b1, 1'b1, 1'b1, MDec, 8'h00, 1'b0);
    n_checks++; if (Q !== 8'hFF) begin n_fail++; $display("FAIL dec_wrap_q: got %h want FF", Q); end
`ifdef UREG_CARRY_EN
    n_checks++; if (CO !== 1'b1) begin n_fail++; $display("FAIL dec_wrap_co: got %b want 1", CO); end
`endif
    // HOLD mode with EN high keeps both Q and CO.
    step(1'b1, 1'b1, 1'b1, MHold, 8'h55, 1'b1);
    n_checks++; if (Q !== 8'hFF) begin n_fail++; $display("FAIL hold_q: got %h want FF", Q); end
`ifdef UREG_CARRY_EN
    n_checks++; if (CO !== 1'b1) begin n_fail++; $display("FAIL hold_co: got %b want 1", CO); end
`endif
    step(1'b1, 1'b1, 1'b1, MDec, 8'h00, 1'b0);
    n_checks++; if (Q !== 8'hFE) begin n_fail++; $display("FAIL dec_q: got %h want FE", Q); end
`ifdef UREG_CARRY_EN
    n_checks++; if (CO !== 1'b0) begin n_fail++; $display("FAIL dec_co: got %b want 0", CO); end
`endif
  endtask

  task automatic test_en_hold();
    logic [7:0] exp_q;
    step(1'b1, 1'b1, 1'b1, MLoad, 8'h10, 1'b0);
    step(1'b1, 1'b1, 1'b1, MInc, 8'h00, 1'b0);
    n_checks++; if (Q !== 8'h11) begin n_fail++; $display("FAIL run_inc_q: got %h want 11", Q); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0, MInc, 8'hAA, 1'b1);
      n_checks++;
      if (Q !== 8'h11) begin n_fail++; $display("FAIL en_low_q[%0d]: got %h want 11", i, Q); end
    end
    exp_q = 8'h11;
    for (int i = 0; i < 2; i++) begin
      exp_q = exp_q + 8'h01;
      step(1'b1, 1'b1, 1'b1, MInc, 8'h00, 1'b0);
      n_checks++;
      if (Q !== exp_q) begin n_fail++; $display("FAIL resume_q[%0d]: got %h want %h", i, Q, exp_q); end
    end
    // Clear and preset together mid-run: clear wins, the INC is dropped.
    step(1'b0, 1'b0, 1'b1, MInc, 8'h00, 1'b0);
    n_checks++; if (Q !== 8'h00) begin n_fail++; $display("FAIL clr_pre_q: got %h want 00", Q); end
    // Preset acts even with EN low.
    step(1'b1, 1'b0, 1'b0, MInc, 8'h00, 1'b0);
    n_checks++; if (Q !== 8'hFF) begin n_fail++; $display("FAIL pre_en_low_q: got %h want FF", Q); end
    // Clear acts even with EN low.
    step(1'b0, 1'b1, 1'b0, MLoad, 8'h77, 1'b0);
    n_checks++; if (Q !== 8'h00) begin n_fail++; $display("FAIL clr_en_low_q: got %h want 00", Q); end
  endtask

  task automatic test_width2();
    step(1'b0, 1'b1, 1'b1, MHold, 8'h00, 1'b0);
    n_checks++; if (Q2 !== 2'b00) begin n_fail++; $display("FAIL w2_clr_q: got %b want 00", Q2); end
    step(1'b1, 1'b1, 1'b1, MLoad, 8'h03, 1'b0);
    n_checks++; if (Q2 !== 2'b11) begin n_fail++; $display("FAIL w2_load_q: got %b want 11", Q2); end
    step(1'b1, 1'b1, 1'b1, MInc, 8'h00, 1'b0);
    n_checks++; if (Q2 !== 2'b00) begin n_fail++; $display("FAIL w2_inc_q: got %b want 00", Q2); end
    n_checks++; if (ZERO2 !== 1'b1) begin n_fail++; $display("FAIL w2_inc_zero: got %b want 1", ZERO2); end
`ifdef UREG_CARRY_EN
    n_checks++; if (CO2 !== 1'b1) begin n_fail++; $display("FAIL w2_inc_co: got %b want 1", CO2); end
`endif
    step(1'b1, 1'b0, 1'b1, MInc, 8'h00, 1'b0);
    n_checks++; if (Q2 !== 2'b10) begin n_fail++; $display("FAIL w2_pre_q: got %b want 10", Q2); end
    n_checks++; if (Qb2 !== 2'b01) begin n_fail++; $display("FAIL w2_pre_qb: got %b want 01", Qb2); end
    step(1'b1, 1'b1, 1'b1, MShr, 8'h00, 1'b1);
    n_checks++; if (Q2 !== 2'b11) begin n_fail++; $display("FAIL w2_shr_q: got %b want 11", Q2); end
    step(1'b1, 1'b1, 1'b1, MShl, 8'h00, 1'b0);
    n_checks++; if (Q2 !== 2'b10) begin n_fail++; $display("FAIL w2_shl_q: got %b want 10", Q2); end
  endtask

  initial begin
    CLR_b = 1'b0;
    PRE_b = 1'b1;
    EN    = 1'b0;
    MODE  = MHold;
    D     = 8'h00;
    SIN   = 1'b0;
    test_reset();
    test_shift();
    test_rotate();
    test_incdec();
    test_en_hold();
    test_width2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
